event_waiter: RTL and testbench

EVENT_WAITER -- requirements
Module: event_waiter

---
 rtl/event_waiter.sv | 142 ++++++++++++++
 tb/tb_event_waiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_waiter.sv
// Event waiter: queues trigger events, services each one for SVC_CYCLES cycles, then holds a done handshake.
// Optional drop counter enabled by defining EVENT_WAITER_DROP_CNT_EN; otherwise drop_cnt is tied to zero.
module event_waiter #(
  parameter int CNT_W      = 4,
  parameter int SVC_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig_ack,
  input  logic             trig_alias,
  input  logic             trig_null,
  input  logic             done_ready,
  output logic             done_valid,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVICE,
    ST_DONE
  } state_t;

  localparam logic [3:0]       SVC_LOAD = 4'(SVC_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_svc_cnt;
  logic [CNT_W-1:0] r_pending;
  logic             r_overflow;
  logic             w_ev;
  logic             w_dec;
  logic             w_drop;
  logic             w_unused_null;

  // Acknowledge and alias name the same event, so both high in one cycle is still one event.
  assign w_ev          = trig_ack | trig_alias;
  // The null trigger is accepted on the port but never creates work.
  assign w_unused_null = trig_null;

  assign w_drop = w_ev && !w_dec && (r_pending == PEND_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pending != '0) begin
          w_state_nxt = ST_SERVICE;
          w_dec       = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (r_svc_cnt == 4'd0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_svc_cnt <= 4'd0;
    end else if (w_dec) begin
      r_svc_cnt <= SVC_LOAD;
    end else if ((r_state == ST_SERVICE) && (r_svc_cnt != 4'd0)) begin
      r_svc_cnt <= r_svc_cnt - 4'd1;
    end
  end

  // A concurrent arrival and dequeue cancel out; a full queue drops the new arrival.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      case ({w_ev, w_dec})
        2'b10: begin
          if (r_pending != PEND_MAX) begin
            r_pending <= r_pending + 1'b1;
          end
        end
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef EVENT_WAITER_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'd0;
`endif

  assign done_valid = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign pending    = r_pending;
  assign overflow   = r_overflow;

  // A presented completion must stay up until downstream takes it.
  a_done_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (done_valid && !done_ready) |=> done_valid);

endmodule

// File: tb/tb_event_waiter.sv
// Self-checking bench for event_waiter: a scoreboard of accepted event arrival edges is
// compared against each done_valid rise, plus directed checks of queue depth, overflow and reset.
module tb_event_waiter;

  localparam int CNT_W = 2;
  localparam int SVC   = 3;

`ifdef EVENT_WAITER_DROP_CNT_EN
  localparam int EXP_DROP_ONE = 1;
  localparam int EXP_DROP_SAT = 255;
`else
  localparam int EXP_DROP_ONE = 0;
  localparam int EXP_DROP_SAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             trig_ack;
  logic             trig_alias;
  logic             trig_null;
  logic             done_ready;
  logic             done_valid;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int arr_q[$];
  int last_hs   = -100;
  int hs_count  = 0;
  int pend_peak = 0;
  int hs0       = 0;
  int mon_arr   = 0;
  int mon_start = 0;
  logic prev_dv    = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_rst   = 1'b0;

  event_waiter #(
    .CNT_W      (CNT_W),
    .SVC_CYCLES (SVC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig_ack   (trig_ack),
    .trig_alias (trig_alias),
    .trig_null  (trig_null),
    .done_ready (done_ready),
    .done_valid (done_valid),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of triggers; accepted events are logged with the edge that samples them.
  task automatic pulse(input logic a, input logic al, input logic nl, input bit accept);
    trig_ack   = a;
    trig_alias = al;
    trig_null  = nl;
    if ((a || al) && accept) arr_q.push_back(cyc + 1);
    tick();
    trig_ack   = 1'b0;
    trig_alias = 1'b0;
    trig_null  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy && !done_valid && (pending == '0) && (arr_q.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, int'(ok), 1);
  endtask

  // Scoreboard: each done_valid rise consumes the oldest accepted arrival and checks its latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      arr_q.delete();
      last_hs = -100;
    end else begin
      if (done_valid && !prev_dv) begin
        if (arr_q.size() == 0) begin
          check("dv_spurious", 1, 0);
        end else begin
          mon_arr   = arr_q.pop_front();
          mon_start = (mon_arr + 1 > last_hs + 1) ? mon_arr + 1 : last_hs + 1;
          check("dv_latency", cyc, mon_start + SVC);
        end
      end
      if (!done_valid && prev_dv) check("dv_hold", int'(prev_ready || !prev_rst), 1);
      if (done_valid && done_ready) begin
        last_hs = cyc + 1;
        hs_count++;
      end
      if (int'(pending) > pend_peak) pend_peak = int'(pending);
    end
    prev_dv    = done_valid;
    prev_ready = done_ready;
    prev_rst   = rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with triggers high: they must be ignored.
    rst_n      = 1'b0;
    trig_ack   = 1'b1;
    trig_alias = 1'b1;
    trig_null  = 1'b1;
    done_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_dv", done_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    trig_ack   = 1'b0;
    trig_alias = 1'b0;
    trig_null  = 1'b0;
    rst_n      = 1'b1;
    tick();
    check("post_rst_pending", pending, 0);

    // Single event, ready held high: done_valid 4 edges later, one-cycle pulse.
    done_ready = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check("t1_pending", pending, 1);
    check("t1_busy_idle", busy, 0);
    tick();
    tick();
    tick();
    check("t1_dv_early", done_valid, 0);
    tick();
    check("t1_dv_high", done_valid, 1);
    check("t1_busy_done", busy, 1);
    tick();
    check("t1_dv_pulse", done_valid, 0);
    check("t1_busy_after", busy, 0);
    wait_idle("t1_drain");

    // Null trigger alone creates no work.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("null_pending", pending, 0);
    tick();
    check("null_busy", busy, 0);

    // Ack and alias together, plus null pulses: one handshake, peak depth one.
    pend_peak = 0;
    hs0 = hs_count;
    pulse(1'b1, 1'b1, 1'b1, 1'b1);
    check("t2_pending", pending, 1);
    repeat (3) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("t2_drain");
    check("t2_handshakes", hs_count - hs0, 1);
    check("t2_peak", pend_peak, 1);

    // Five back-to-back events with downstream stalled: queue fills, fifth is dropped.
    done_ready = 1'b0;
    hs0 = hs_count;
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, i < 4);
    check("t3_pending", pending, 3);
    check("t3_overflow", overflow, 1);
    check("t3_drop", drop_cnt, EXP_DROP_ONE);
    check("t3_dv", done_valid, 1);
    check("t3_busy", busy, 1);
    done_ready = 1'b1;
    wait_idle("t3_drain");
    check("t3_handshakes", hs_count - hs0, 4);
    check("t3_overflow_sticky", overflow, 1);

    // Long stall with continuous triggers: drop counter saturates.
    done_ready = 1'b0;
    hs0 = hs_count;
    for (int i = 0; i < 300; i++) pulse(1'b1, 1'b0, 1'b0, i < 4);
    check("sat_drop", drop_cnt, EXP_DROP_SAT);
    check("sat_pending", pending, 3);
    check("sat_overflow", overflow, 1);
    done_ready = 1'b1;
    wait_idle("sat_drain");
    check("sat_handshakes", hs_count - hs0, 4);

    // Event on the IDLE->SERVICE edge with one pending: depth holds at one.
    hs0 = hs_count;
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_pending", pending, 1);
    check("t4_busy", busy, 1);
    wait_idle("t4_drain");
    check("t4_handshakes", hs_count - hs0, 2);

    // Reset during SERVICE with two queued: everything discarded.
    done_ready = 1'b0;
    hs0 = hs_count;
    repeat (3) pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_pending", pending, 2);
    check("t5_busy", busy, 1);
    check("t5_dv", done_valid, 0);
    rst_n    = 1'b0;
    trig_ack = 1'b1;
    tick();
    trig_ack = 1'b0;
    rst_n    = 1'b1;
    check("t5_rst_pending", pending, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_dv", done_valid, 0);
    check("t5_rst_overflow", overflow, 0);
    check("t5_rst_drop", drop_cnt, 0);
    done_ready = 1'b1;
    repeat (20) tick();
    check("t5_handshakes", hs_count - hs0, 0);
    check("t5_busy_after", busy, 0);
    check("t5_dv_after", done_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
